// File: rtl/face_result_tx_ctrl.sv
// Record FIFO between detect_face and uart_tcvr; streams buffered records as
// per-frame bursts (count header + record bytes) under CTS flow control.
module face_result_tx_ctrl #(
    parameter int RECORD_BYTES = 16,
    parameter int MAX_RECORDS  = 100
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rec_valid,
    input  logic [RECORD_BYTES*8-1:0] rec_data,
    output logic                      rec_ready,
    input  logic                      frame_done,
    input  logic                      cts,
    output logic [7:0]                tx_data,
    output logic                      tx_start,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [7:0]                fifo_count,
    output logic [15:0]               drop_count
);
    localparam int RW = RECORD_BYTES * 8;
    localparam int BW = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam int PW = (MAX_RECORDS > 1) ? $clog2(MAX_RECORDS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, POP, BYTE} state_t;

    state_t        state;
    logic [RW-1:0] mem [MAX_RECORDS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [RW-1:0] shreg;
    logic [BW-1:0] byte_idx;
    logic [7:0]    remaining;
    logic          pending;
    logic          full, push, pop;

    // full is taken from the registered count, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge.
    assign full      = (fifo_count == 8'(MAX_RECORDS));
    assign push      = rec_valid & ~full;
    assign pop       = (state == POP);
    assign rec_ready = ~full;
    assign busy      = (state != IDLE);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_RECORDS - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rec_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
            shreg      <= '0;
            byte_idx   <= '0;
            remaining  <= '0;
            pending    <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + 8'd1;
            else if (!push && pop) fifo_count <= fifo_count - 8'd1;
            if (rec_valid && full && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            if (frame_done && state != IDLE) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_done || pending) begin
                        state     <= HDR;
                        pending   <= 1'b0;
                        remaining <= fifo_count;
                    end
                end
                HDR: begin
                    if (!tx_start) begin
                        if (cts) begin
                            tx_start <= 1'b1;
                            tx_data  <= remaining;
                        end
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        tx_data  <= '0;
                        state    <= (remaining == 8'd0) ? IDLE : POP;
                    end
                end
                POP: begin
                    shreg     <= mem[rd_ptr];
                    remaining <= remaining - 8'd1;
                    byte_idx  <= '0;
                    state     <= BYTE;
                end
                BYTE: begin
                    if (!tx_start) begin
                        if (cts) begin
                            tx_start <= 1'b1;
                            tx_data  <= shreg[7:0];
                        end
                    end else if (tx_done) begin
                        tx_start <= 1'b0;
                        tx_data  <= '0;
                        shreg    <= shreg >> 8;
                        if (byte_idx == BW'(RECORD_BYTES - 1))
                            state <= (remaining == 8'd0) ? IDLE : POP;
                        else
                            byte_idx <= byte_idx + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
